// File: rtl/client_copy_engine.sv
// Block-copy initiator on the data memory client port.
// Alternating read/write transfers of word, halfword or byte.
module client_copy_engine (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Abort,
  input  logic [31:0] SrcAddr,
  input  logic [31:0] DstAddr,
  input  logic [15:0] Len,
  input  logic [31:0] ClientMemRead,
  output logic [31:0] ClientMemAddr,
  output logic [31:0] ClientMemWrite,
  output logic [1:0]  CWDM,
  output logic [1:0]  CRDM,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] src_ptr_q, src_ptr_d;
  logic [31:0] dst_ptr_q, dst_ptr_d;
  logic [15:0] rem_q, rem_d;

  logic [1:0]  sz;
  logic [15:0] step;

  // Largest transfer that still fits in the bytes remaining.
  always_comb begin
    sz   = 2'd0;
    step = 16'd0;
    unique case (1'b1)
      (rem_q >= 16'd4): begin
        sz   = 2'd3;
        step = 16'd4;
      end
      (rem_q == 16'd2),
      (rem_q == 16'd3): begin
        sz   = 2'd2;
        step = 16'd2;
      end
      (rem_q == 16'd1): begin
        sz   = 2'd1;
        step = 16'd1;
      end
      default: begin
        sz   = 2'd0;
        step = 16'd0;
      end
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      src_ptr_q <= 32'd0;
      dst_ptr_q <= 32'd0;
      rem_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
    end
  end

  // Next state; a write in WR commits even when aborted.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Len != 16'd0) begin
            src_ptr_d = SrcAddr;
            dst_ptr_d = DstAddr;
            rem_d     = Len;
            state_d   = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        state_d = Abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        src_ptr_d = src_ptr_q + {16'd0, step};
        dst_ptr_d = dst_ptr_q + {16'd0, step};
        rem_d     = rem_q - step;
        if (Abort)
          state_d = S_IDLE;
        else if (rem_d == 16'd0)
          state_d = S_DONE;
        else
          state_d = S_RD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; write data passes through.
  always_comb begin
    ClientMemAddr  = 32'd0;
    ClientMemWrite = 32'd0;
    CWDM           = 2'd0;
    CRDM           = 2'd0;
    Busy           = 1'b0;
    Done           = 1'b0;
    Remaining      = rem_q;
    unique case (state_q)
      S_RD: begin
        ClientMemAddr = src_ptr_q;
        CRDM          = sz;
        Busy          = 1'b1;
      end
      S_WR: begin
        ClientMemAddr  = dst_ptr_q;
        ClientMemWrite = ClientMemRead;
        CWDM           = sz;
        Busy           = 1'b1;
      end
      S_DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_client_copy_engine.sv
// Directed bench for client_copy_engine.
// Byte-addressed memory model with registered read data.
module tb_client_copy_engine;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic        Abort;
  logic [31:0] SrcAddr;
  logic [31:0] DstAddr;
  logic [15:0] Len;
  logic [31:0] ClientMemRead;
  logic [31:0] ClientMemAddr;
  logic [31:0] ClientMemWrite;
  logic [1:0]  CWDM;
  logic [1:0]  CRDM;
  logic        Busy;
  logic        Done;
  logic [15:0] Remaining;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [logic [31:0]];

  int          done_at;
  int          ndone;
  int          nrd;
  int          nwr;
  int          nboth;
  logic [11:0] rd_seq;
  logic        busy_after;

  client_copy_engine dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Start         (Start),
    .Abort         (Abort),
    .SrcAddr       (SrcAddr),
    .DstAddr       (DstAddr),
    .Len           (Len),
    .ClientMemRead (ClientMemRead),
    .ClientMemAddr (ClientMemAddr),
    .ClientMemWrite(ClientMemWrite),
    .CWDM          (CWDM),
    .CRDM          (CRDM),
    .Busy          (Busy),
    .Done          (Done),
    .Remaining     (Remaining)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rdm(input logic [31:0] a);
    if (mem.exists(a))
      return mem[a];
    return 8'h00;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd3) ? 4 : int'(s);
  endfunction

  // Memory: read data registered, writes at the edge.
  always @(posedge Clk) begin
    logic [31:0] r;
    if (CRDM != 2'd0) begin
      r = 32'd0;
      for (int i = 0; i < nbytes(CRDM); i++)
        r[8*i +: 8] = rdm(ClientMemAddr + i);
      ClientMemRead <= r;
    end
    if (CWDM != 2'd0)
      for (int i = 0; i < nbytes(CWDM); i++)
        mem[ClientMemAddr + i] = ClientMemWrite[8*i +: 8];
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd32(input logic [31:0] a);
    return {rdm(a + 3), rdm(a + 2), rdm(a + 1), rdm(a)};
  endfunction

  task automatic clear_dst();
    for (int i = 0; i < 8; i++)
      mem[32'h9000 + i] = 8'h00;
  endtask

  // Start a copy; ab/rs/rt pick the cycle for Abort, re-Start, Rst.
  task automatic run(input logic [31:0] s, input logic [31:0] d,
                     input logic [15:0] l, input int ab,
                     input int rs, input int rt);
    done_at = 0;
    ndone = 0;
    nrd = 0;
    nwr = 0;
    nboth = 0;
    rd_seq = '0;
    busy_after = 1'b1;
    @(negedge Clk);
    SrcAddr = s;
    DstAddr = d;
    Len = l;
    Start = 1'b1;
    Abort = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      Start = (k == rs);
      Abort = (k == ab);
      if (k == rs)
        Len = 16'd3;
      if (k == rt) begin
        Rst = 1'b1;
        #1;
        check("rst_async",
              {30'd0, ClientMemAddr, CRDM, CWDM, Busy, Done},
              64'd0);
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
      if (k == ab + 1)
        busy_after = Busy;
      if (Done) begin
        ndone++;
        done_at = k;
      end
      if (CRDM != 2'd0) begin
        if (nrd < 6)
          rd_seq[2*nrd +: 2] = CRDM;
        nrd++;
      end
      if (CWDM != 2'd0)
        nwr++;
      if (CRDM != 2'd0 && CWDM != 2'd0)
        nboth++;
    end
    Abort = 1'b0;
  endtask

  initial begin
    Rst = 1'b1;
    Start = 1'b0;
    Abort = 1'b0;
    SrcAddr = '0;
    DstAddr = '0;
    Len = '0;
    for (int i = 0; i < 8; i++)
      mem[32'h8000 + i] = 8'(i + 1);
    clear_dst();
    #1;
    check("reset_out",
          {ClientMemAddr, CRDM, CWDM, Busy, Done, Remaining},
          64'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    check("reset_idle", {63'd0, Busy}, 64'd0);

    run(32'h8000, 32'h9000, 16'd8, -5, -5, -5);
    check("l8_done_at", done_at, 5);
    check("l8_ndone", ndone, 1);
    check("l8_nrd", nrd, 2);
    check("l8_lo", rd32(32'h9000), 32'h04030201);
    check("l8_hi", rd32(32'h9004), 32'h08070605);
    check("l8_rem", Remaining, 0);
    check("l8_both", nboth, 0);

    clear_dst();
    run(32'h8000, 32'h9000, 16'd7, -5, -5, -5);
    check("l7_seq", rd_seq, {6'd0, 2'd1, 2'd2, 2'd3});
    check("l7_done_at", done_at, 7);
    check("l7_lo", rd32(32'h9000), 32'h04030201);
    check("l7_hi", rd32(32'h9004), 32'h00070605);
    check("l7_both", nboth, 0);

    run(32'h8000, 32'h9000, 16'd0, -5, -5, -5);
    check("l0_done_at", done_at, 1);
    check("l0_nrd", nrd, 0);
    check("l0_nwr", nwr, 0);

    clear_dst();
    run(32'h8000, 32'h9000, 16'd8, 2, -5, -5);
    check("ab_lo", rd32(32'h9000), 32'h04030201);
    check("ab_hi", rd32(32'h9004), 32'h00000000);
    check("ab_rem", Remaining, 4);
    check("ab_ndone", ndone, 0);
    check("ab_busy", {63'd0, busy_after}, 64'd0);

    clear_dst();
    run(32'h8000, 32'h9000, 16'd8, -5, 2, -5);
    check("rs_ndone", ndone, 1);
    check("rs_done_at", done_at, 5);
    check("rs_hi", rd32(32'h9004), 32'h08070605);

    run(32'h8000, 32'h9000, 16'd8, -5, -5, 3);
    check("rst_idle", {63'd0, Busy}, 64'd0);

    run(32'h8000, 32'hFFFF_FFFE, 16'd4, -5, -5, -5);
    check("wr_done_at", done_at, 3);
    check("wr_ptr", dut.dst_ptr_q, 32'h0000_0002);
    check("wr_data", rd32(32'hFFFF_FFFE), 32'h04030201);
    check("wr_rem", Remaining, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/client_copy_engine.md
# client_copy_engine

Block-copy initiator that drives the client port of the data memory (ClientMemAddr, ClientMemWrite, CWDM, CRDM, ClientMemRead). On a start command it copies Len bytes from SrcAddr to DstAddr by alternating client reads and writes. Each transfer is a word, halfword or byte, chosen from the bytes remaining. It sits beside the CPU, owns the client port exclusively, and leaves the CPU port untouched.

## Interface
- No parameters.
- Clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  command strobe; sampled only in IDLE.
- Abort  in  1  cancel a running copy; sampled in RD and WR.
- SrcAddr  in  32  source byte address; captured at Start.
- DstAddr  in  32  destination byte address; captured at Start.
- Len  in  16  byte count; captured at Start.
- ClientMemRead  in  32  memory client read data, registered by the memory, zero-extended per size.
- ClientMemAddr  out  32  client byte address.
- ClientMemWrite  out  32  client write data.
- CWDM  out  2  client write size: 0 none, 1 byte, 2 halfword, 3 word.
- CRDM  out  2  client read size, same encoding.
- Busy  out  1  high in RD and WR.
- Done  out  1  one-cycle completion pulse.
- Remaining  out  16  bytes not yet written.

## Operation
- States: IDLE, RD, WR, DONE. Registers: state, src_ptr[31:0], dst_ptr[31:0], rem[15:0].
- All outputs are decoded from registered state only. No input reaches an output combinationally, except ClientMemWrite in WR (below).
- Size select: sz = 3 (4 bytes) if rem ≥ 4; sz = 2 (2 bytes) if rem is 2 or 3; sz = 1 (1 byte) if rem is 1.
- IDLE
  - All outputs 0.
  - Start=1 with Len≠0: load src_ptr, dst_ptr and rem; go to RD.
  - Start=1 with Len=0: go to DONE; no memory access.
- RD
  - ClientMemAddr = src_ptr; CRDM = sz; CWDM = 0.
  - Next state WR.
- WR
  - ClientMemAddr = dst_ptr; CWDM = sz; CRDM = 0; ClientMemWrite = ClientMemRead (pass-through).
  - At the edge: src_ptr += bytes(sz), dst_ptr += bytes(sz), rem -= bytes(sz).
  - If the new rem is 0, go to DONE; otherwise go to RD.
- DONE: Done = 1; next state IDLE.
- Abort, evaluated before the normal transition:
  - In RD: go to IDLE; the read is discarded.
  - In WR: the write presented this cycle still commits (the memory samples at the same edge); go to IDLE.
  - Abort never produces a Done pulse, and Remaining holds its value in IDLE.
- Start outside IDLE is ignored; Start and Abort together in IDLE means Start.
- Pointers wrap modulo 2^32.
- No alignment requirement: multi-byte transfers use little-endian byte order (addr, addr+1, …), matching the memory.
- Overlapping regions are copied in forward chunk order.
  - dst ≤ src: the copy is correct.
  - dst > src with overlap: the result is whatever the forward chunk order produces; this is not an error.
- Contention with CPU-port accesses to the same bytes is outside this block's scope.
- Remaining = rem, which is 0 after reset and after a completed copy.

## Timing
- Reset values: state IDLE, pointers 0, rem 0, all outputs 0.
- Asserting Rst mid-copy returns to IDLE immediately; no further client strobes are issued.
- Cycle 0: Start is sampled. Cycle 1: RD. Cycle 2: WR. The pattern repeats as 2 cycles per transfer.
- Transfer count N = floor(Len/4) + (Len mod 4 ≥ 2) + (Len mod 4 odd).
- Done is high in cycle 2N+1 after the Start edge; a new Start is accepted the cycle after Done.
- Len=0: Done is high in cycle 1.
- CRDM and CWDM are never nonzero in the same cycle.

## Test plan
- Rst=1, then preload 0x8000..0x8007 = 01..08. Start with Src=0x8000, Dst=0x9000, Len=8 → 2 word transfers; Done 5 cycles after Start; 0x9000..0x9007 = 01..08; Remaining = 0.
- Len=7 from 0x8000 to 0x9000 → CRDM sequence 3, 2, 1; Done 7 cycles after Start; 0x9007 is unchanged (still 00).
- Len=0 → Done in cycle 1; CRDM and CWDM stay 0 throughout.
- Abort asserted in the first WR of a Len=8 copy → bytes 0x9000..0x9003 written, 0x9004..0x9007 remain 00; Remaining = 4; no Done pulse; Busy=0 next cycle.
- Start pulsed again while Busy → ignored: the copy runs unchanged and exactly one Done pulse is seen.
- Rst asserted mid-copy (in RD of the second transfer) → all outputs 0 asynchronously. After Rst deasserts, a new copy of 0x8000..0x8003 to 0xFFFFFFFE with Len=4 wraps dst_ptr to 0x00000002 after its single word transfer.
